// File: rtl/viterbi_decoder.sv
// Hard-decision Viterbi decoder for the rate-1/2, K=3 (7,5 octal) convolutional code.
// Four-state add-compare-select with register-exchange survivors and a fixed decision depth.
module viterbi_decoder #(
  parameter int TB_DEPTH = 16,
  parameter int PM_W     = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic [1:0]      in_code,
  output logic            out_valid,
  output logic            out_bit,
  output logic [PM_W-1:0] min_pm
);

  // Handshake: in_valid high means in_code is consumed on this rising edge; there is no
  // back-pressure. out_valid is a one-cycle pulse qualifying out_bit; out_bit and min_pm
  // hold their values while no symbol is accepted.

  localparam int NS = 4;
  localparam int CW = $clog2(TB_DEPTH + 1);
  localparam logic [PM_W-1:0] PM_MAX   = {PM_W{1'b1}};
  localparam logic [PM_W-1:0] PM_INIT  = (PM_W >= 3) ? PM_W'(6) : PM_MAX;
  localparam logic [CW-1:0]   FILL_MAX = CW'(TB_DEPTH);

  logic [NS-1:0][PM_W-1:0]     pm;
  logic [NS-1:0][TB_DEPTH-1:0] surv;
  logic [CW-1:0]               fill;

  logic [NS-1:0][PM_W-1:0]     pm_pre;
  logic [NS-1:0][PM_W-1:0]     pm_norm;
  logic [NS-1:0][TB_DEPTH-1:0] surv_sel;
  logic [NS-1:0][TB_DEPTH-1:0] surv_new;
  logic [NS-1:0]               sel;
  logic [PM_W-1:0]             min_pre;
  logic [1:0]                  best;
  logic [CW-1:0]               fill_next;

  function automatic logic [1:0] hamming(input logic [1:0] a, input logic [1:0] b);
    logic [1:0] d;
    d = a ^ b;
    return {1'b0, d[1]} + {1'b0, d[0]};
  endfunction

  function automatic logic [PM_W-1:0] sat_add(input logic [PM_W-1:0] m, input logic [1:0] bm);
    logic [PM_W:0] sum;
    sum = {1'b0, m} + (PM_W+1)'(bm);
    return sum[PM_W] ? PM_MAX : sum[PM_W-1:0];
  endfunction

  // New state {x,a} is reached from {a,0} and {a,1}; ties keep the {a,0} predecessor.
  for (genvar g = 0; g < NS; g++) begin : g_acs
    localparam logic       X  = (g >= 2);
    localparam logic       A  = (g % 2 == 1);
    localparam int         P0 = (g % 2) * 2;
    localparam int         P1 = P0 + 1;
    localparam logic [1:0] E0 = {X ^ A, X};
    localparam logic [1:0] E1 = {X ^ A ^ 1'b1, X ^ 1'b1};

    logic [PM_W-1:0] cand0;
    logic [PM_W-1:0] cand1;

    assign cand0       = sat_add(pm[P0], hamming(in_code, E0));
    assign cand1       = sat_add(pm[P1], hamming(in_code, E1));
    assign sel[g]      = (cand1 < cand0);
    assign pm_pre[g]   = sel[g] ? cand1 : cand0;
    assign surv_sel[g] = sel[g] ? surv[P1] : surv[P0];
    assign surv_new[g] = (surv_sel[g] << 1) | TB_DEPTH'(X);
  end

  // Strict compare keeps the lowest-index state on equal metrics.
  always_comb begin
    min_pre = pm_pre[0];
    best    = 2'd0;
    pm_norm = '0;
    for (int i = 1; i < NS; i++) begin
      if (pm_pre[i] < min_pre) begin
        min_pre = pm_pre[i];
        best    = 2'(i);
      end
    end
    for (int i = 0; i < NS; i++) begin
      pm_norm[i] = pm_pre[i] - min_pre;
    end
  end

  assign fill_next = !in_valid           ? fill :
                     (fill == FILL_MAX)  ? fill :
                                           fill + CW'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pm        <= {PM_INIT, PM_INIT, PM_INIT, {PM_W{1'b0}}};
      surv      <= '0;
      fill      <= '0;
      out_valid <= 1'b0;
      out_bit   <= 1'b0;
      min_pm    <= '0;
    end else begin
      out_valid <= in_valid && (fill_next == FILL_MAX);
      if (in_valid) begin
        pm      <= pm_norm;
        surv    <= surv_new;
        fill    <= fill_next;
        min_pm  <= min_pre;
        out_bit <= surv_new[best][TB_DEPTH-1];
      end
    end
  end

endmodule

// File: tb/tb_viterbi_decoder.sv
// Self-checking bench for viterbi_decoder: directed streams from a reference (7,5) encoder
// plus a random payload with isolated symbol errors, checked through an expected-bit queue.
module tb_viterbi_decoder;

  localparam int TB_DEPTH = 16;
  localparam int PM_W     = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            in_valid = 1'b0;
  logic [1:0]      in_code = 2'b00;
  logic            out_valid;
  logic            out_bit;
  logic [PM_W-1:0] min_pm;

  logic [0:0] exp_q[$];
  int         n_cmp = 0;
  int         n_err = 0;
  logic [1:0] enc_st = 2'b00;
  logic [7:0] pat_bits = 8'b0000_1101;

  always #5 clk = ~clk;

  viterbi_decoder #(.TB_DEPTH(TB_DEPTH), .PM_W(PM_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_code  (in_code),
    .out_valid(out_valid),
    .out_bit  (out_bit),
    .min_pm   (min_pm)
  );

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; in_code = 2'b00;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    enc_st = 2'b00;
    exp_q.delete();
  endtask

  task automatic step(input logic v, input logic [1:0] c);
    in_valid = v; in_code = c;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic enc_next(input logic x, output logic [1:0] sym);
    sym    = {x ^ enc_st[1] ^ enc_st[0], x ^ enc_st[0]};
    enc_st = {x, enc_st[1]};
  endtask

  function automatic logic base_bit(input int k);
    return (k < 8) ? pat_bits[k[2:0]] : 1'b0;
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [PM_W-1:0] exp_pm;
    rst = 1'b1; in_valid = 1'b0; in_code = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (out_bit !== 1'b0) begin n_err++; $display("FAIL reset_out_bit: got %b want 0", out_bit); end
    n_cmp++; if (min_pm !== 4'd0) begin n_err++; $display("FAIL reset_min_pm: got %0d want 0", min_pm); end
    for (int i = 0; i < 4; i++) begin
      exp_pm = (i == 0) ? 4'd0 : 4'd6;
      n_cmp++;
      if (dut.pm[i] !== exp_pm) begin n_err++; $display("FAIL reset_pm%0d: got %0d want %0d", i, dut.pm[i], exp_pm); end
    end
    rst = 1'b0;
    enc_st = 2'b00;
    exp_q.delete();
  endtask

  task automatic test_async_reset();
    logic [1:0] sym;
    do_reset();
    for (int k = 0; k < 17; k++) begin
      enc_next(1'b1, sym);
      if (k == 16) sym = sym ^ 2'b10;
      step(1'b1, sym);
    end
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL pre_areset_valid: got %b want 1", out_valid); end
    n_cmp++; if (out_bit !== 1'b1) begin n_err++; $display("FAIL pre_areset_bit: got %b want 1", out_bit); end
    n_cmp++; if (min_pm !== 4'd1) begin n_err++; $display("FAIL pre_areset_min_pm: got %0d want 1", min_pm); end
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL areset_valid: got %b want 0", out_valid); end
    n_cmp++; if (out_bit !== 1'b0) begin n_err++; $display("FAIL areset_bit: got %b want 0", out_bit); end
    n_cmp++; if (min_pm !== 4'd0) begin n_err++; $display("FAIL areset_min_pm: got %0d want 0", min_pm); end
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_error_free();
    logic [1:0] sym;
    logic       ev, eb;
    do_reset();
    for (int k = 0; k < 20; k++) begin
      enc_next(base_bit(k), sym);
      exp_q.push_back(base_bit(k));
      step(1'b1, sym);
      ev = (k >= TB_DEPTH - 1);
      n_cmp++; if (out_valid !== ev) begin n_err++; $display("FAIL clean_valid k=%0d: got %b want %b", k, out_valid, ev); end
      if (out_valid === 1'b1 && exp_q.size() > 0) begin
        eb = exp_q.pop_front();
        n_cmp++; if (out_bit !== eb) begin n_err++; $display("FAIL clean_bit k=%0d: got %b want %b", k, out_bit, eb); end
      end
      n_cmp++; if (min_pm !== 4'd0) begin n_err++; $display("FAIL clean_min_pm k=%0d: got %0d want 0", k, min_pm); end
    end
  endtask

  task automatic test_single_error();
    logic [1:0] sym;
    logic       ev, eb;
    logic [PM_W-1:0] em;
    do_reset();
    for (int k = 0; k < 20; k++) begin
      enc_next(base_bit(k), sym);
      if (k == 2) sym = sym ^ 2'b10;
      exp_q.push_back(base_bit(k));
      step(1'b1, sym);
      ev = (k >= TB_DEPTH - 1);
      n_cmp++; if (out_valid !== ev) begin n_err++; $display("FAIL err1_valid k=%0d: got %b want %b", k, out_valid, ev); end
      if (out_valid === 1'b1 && exp_q.size() > 0) begin
        eb = exp_q.pop_front();
        n_cmp++; if (out_bit !== eb) begin n_err++; $display("FAIL err1_bit k=%0d: got %b want %b", k, out_bit, eb); end
      end
      if (k <= 2) begin
        em = (k == 2) ? 4'd1 : 4'd0;
        n_cmp++; if (min_pm !== em) begin n_err++; $display("FAIL err1_min_pm k=%0d: got %0d want %0d", k, min_pm, em); end
      end
    end
  endtask

  task automatic test_gaps();
    logic [1:0] sym;
    logic       ev, eb;
    int         gap;
    do_reset();
    for (int k = 0; k < 20; k++) begin
      enc_next(base_bit(k), sym);
      exp_q.push_back(base_bit(k));
      step(1'b1, sym);
      ev = (k >= TB_DEPTH - 1);
      n_cmp++; if (out_valid !== ev) begin n_err++; $display("FAIL gap_valid k=%0d: got %b want %b", k, out_valid, ev); end
      if (out_valid === 1'b1 && exp_q.size() > 0) begin
        eb = exp_q.pop_front();
        n_cmp++; if (out_bit !== eb) begin n_err++; $display("FAIL gap_bit k=%0d: got %b want %b", k, out_bit, eb); end
      end
      gap = (k == 4) ? 3 : (k == 9) ? 1 : 0;
      for (int g = 0; g < gap; g++) begin
        step(1'b0, 2'b11);
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL gap_idle_valid k=%0d: got %b want 0", k, out_valid); end
        n_cmp++; if (out_bit !== 1'b0) begin n_err++; $display("FAIL gap_idle_bit k=%0d: got %b want 0", k, out_bit); end
        n_cmp++; if (min_pm !== 4'd0) begin n_err++; $display("FAIL gap_idle_min_pm k=%0d: got %0d want 0", k, min_pm); end
      end
    end
  endtask

  task automatic test_midstream_reset();
    logic [1:0] sym;
    logic       x, ev, eb;
    do_reset();
    for (int k = 0; k < 20; k++) begin
      x = 1'($urandom_range(0, 1));
      enc_next(x, sym);
      exp_q.push_back(x);
      step(1'b1, sym);
      if (out_valid === 1'b1 && exp_q.size() > 0) begin
        eb = exp_q.pop_front();
        n_cmp++; if (out_bit !== eb) begin n_err++; $display("FAIL mid_pre_bit k=%0d: got %b want %b", k, out_bit, eb); end
      end
    end
    #2 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    enc_st = 2'b00;
    exp_q.delete();
    for (int k = 0; k < 20; k++) begin
      enc_next(1'b0, sym);
      exp_q.push_back(1'b0);
      step(1'b1, sym);
      ev = (k >= TB_DEPTH - 1);
      n_cmp++; if (out_valid !== ev) begin n_err++; $display("FAIL mid_valid k=%0d: got %b want %b", k, out_valid, ev); end
      if (out_valid === 1'b1 && exp_q.size() > 0) begin
        eb = exp_q.pop_front();
        n_cmp++; if (out_bit !== eb) begin n_err++; $display("FAIL mid_bit k=%0d: got %b want %b", k, out_bit, eb); end
      end
      n_cmp++; if (min_pm !== 4'd0) begin n_err++; $display("FAIL mid_min_pm k=%0d: got %0d want 0", k, min_pm); end
    end
  endtask

  task automatic test_random_payload();
    logic [1:0] sym;
    logic       x, ev, eb;
    int         next_err;
    int         total;
    int         n_outs;
    do_reset();
    total    = 1000 + TB_DEPTH - 1;
    next_err = $urandom_range(4, 12);
    n_outs   = 0;
    for (int k = 0; k < total; k++) begin
      x = (k < 1000) ? 1'($urandom_range(0, 1)) : 1'b0;
      enc_next(x, sym);
      if (k == next_err && k < 1000) begin
        sym      = sym ^ (($urandom_range(0, 1) == 1) ? 2'b10 : 2'b01);
        next_err = k + $urandom_range(10, 24);
      end
      exp_q.push_back(x);
      step(1'b1, sym);
      ev = (k >= TB_DEPTH - 1);
      n_cmp++;
      if (out_valid !== ev) begin
        n_err++;
        if (n_err < 20) $display("FAIL rand_valid k=%0d: got %b want %b", k, out_valid, ev);
      end
      if (out_valid === 1'b1 && exp_q.size() > 0) begin
        eb = exp_q.pop_front();
        n_outs++;
        n_cmp++;
        if (out_bit !== eb) begin
          n_err++;
          if (n_err < 20) $display("FAIL rand_bit k=%0d: got %b want %b", k, out_bit, eb);
        end
      end
    end
    n_cmp++;
    if (n_outs !== 1000) begin n_err++; $display("FAIL rand_out_count: got %0d want 1000", n_outs); end
  endtask

  initial begin
    test_reset();
    test_async_reset();
    test_error_free();
    test_single_error();
    test_gaps();
    test_midstream_reset();
    test_random_payload();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
